// File: rtl/mux_port_arbiter.sv
// -----------------------------------------------------------------------------
// mux_port_arbiter
//
// Round-robin arbiter that hands one shared resource (behind a 4:1 datapath
// mux) to one of four requesters at a time. A grant lives through three
// phases:
//   IDLE  : no grant held; arbitrate among req starting at the rotating ptr.
//   START : one cycle in which 'start' tells the resource to begin.
//   WAIT  : wait for mem_done. If mem_done does not arrive within MAX_WAIT
//           cycles, the grant is forcibly released and 'timeout' pulses.
// On release, ptr moves to the requester after the one just served, which
// gives a fair rotation when every requester is asking.
//
// All outputs come straight from flops, so req has no combinational path to
// any output. sel keeps its last value while idle so the mux does not glitch.
//
// Parameters:
//   MAX_WAIT  WAIT cycles allowed before forced release (legal 1..15)
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous, active-high
//   req[3:0]  level request, bit i = requester i
//   mem_done  completion pulse from the shared resource
//   grant[3:0] one-hot grant, zero when no grant is held
//   sel[1:0]  index of the granted requester (held while idle)
//   start     one-cycle pulse: resource may begin
//   busy      high while a grant is held (START or WAIT)
//   timeout   one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module mux_port_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       mem_done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       start,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t     r_state, r_state_next;
    logic [3:0] r_grant, r_grant_next;
    logic [1:0] r_sel, r_sel_next;
    logic       r_start, r_start_next;
    logic       r_busy, r_busy_next;
    logic       r_timeout, r_timeout_next;
    logic [1:0] r_ptr, r_ptr_next;
    logic [3:0] r_wait_cnt, r_wait_cnt_next;

    // -------------------------------------------------------------------------
    // Round-robin pick: rotate req so that position 0 is requester ptr, take
    // the lowest set position, then rotate the offset back to an index.
    // -------------------------------------------------------------------------
    logic [3:0] w_rot_req;
    logic [1:0] w_off;
    logic [1:0] w_pick;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] w_idx;
            assign w_idx        = r_ptr + 2'(gi);
            assign w_rot_req[gi] = req[w_idx];
        end
    endgenerate

    always_comb begin
        w_off = 2'd0;
        // Walk from the highest offset down so the lowest set offset wins.
        for (int i = 3; i >= 0; i--) begin
            if (w_rot_req[i]) begin
                w_off = 2'(i);
            end
        end
    end

    assign w_pick = r_ptr + w_off;

    // Last allowed WAIT cycle: releasing at the end of it gives exactly
    // MAX_WAIT WAIT cycles in total.
    logic w_cnt_last;
    assign w_cnt_last = (r_wait_cnt == 4'(MAX_WAIT - 1));

    // -------------------------------------------------------------------------
    // State register (and all registered outputs / datapath state)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 4'd0;
            r_sel      <= 2'd0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= 2'd0;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= r_state_next;
            r_grant    <= r_grant_next;
            r_sel      <= r_sel_next;
            r_start    <= r_start_next;
            r_busy     <= r_busy_next;
            r_timeout  <= r_timeout_next;
            r_ptr      <= r_ptr_next;
            r_wait_cnt <= r_wait_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    r_state_next = ST_START;
                end
            end
            ST_START: begin
                r_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done || w_cnt_last) begin
                    r_state_next = ST_IDLE;
                end
            end
            default: begin
                r_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values for the registered outputs. start and timeout
    // default low so they can only ever be single-cycle pulses.
    // -------------------------------------------------------------------------
    always_comb begin
        r_grant_next    = r_grant;
        r_sel_next      = r_sel;
        r_start_next    = 1'b0;
        r_busy_next     = r_busy;
        r_timeout_next  = 1'b0;
        r_ptr_next      = r_ptr;
        r_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    r_grant_next = 4'b0001 << w_pick;
                    r_sel_next   = w_pick;
                    r_start_next = 1'b1;
                    r_busy_next  = 1'b1;
                end
            end
            ST_START: begin
                // mem_done is deliberately not looked at here.
                r_wait_cnt_next = 4'd0;
            end
            ST_WAIT: begin
                if (mem_done || w_cnt_last) begin
                    r_grant_next   = 4'd0;
                    r_busy_next    = 1'b0;
                    r_ptr_next     = r_sel + 2'd1;
                    // A completion on the last cycle is a normal release.
                    r_timeout_next = ~mem_done;
                end else begin
                    r_wait_cnt_next = r_wait_cnt + 4'd1;
                end
            end
            default: begin
                r_grant_next = 4'd0;
                r_busy_next  = 1'b0;
            end
        endcase
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign start   = r_start;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_port_arbiter
//
// Drives mux_port_arbiter through directed scenarios and a randomized run.
// A transaction-level reference model tracks who owns the resource, how many
// cycles the current grant has lived, and the round-robin pointer; every cycle
// all outputs are compared against it, plus literal checks for the directed
// scenarios.
// -----------------------------------------------------------------------------
module tb_mux_port_arbiter;

    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'd0;
    logic       mem_done = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       start;
    logic       busy;
    logic       timeout;

    mux_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .mem_done (mem_done),
        .grant    (grant),
        .sel      (sel),
        .start    (start),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    // owner = -1 when nothing is granted. age counts edges since the grant was
    // taken: age 0 is the start cycle, age k>=1 is the k-th WAIT cycle.
    int   m_owner = -1;
    int   m_age   = 0;
    int   m_ptr   = 0;
    int   m_sel   = 0;
    logic m_start = 1'b0;
    logic m_to    = 1'b0;

    task automatic model_edge(input logic [3:0] rq, input logic md, input logic rs);
        if (rs) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_sel = 0;
            m_start = 1'b0; m_to = 1'b0;
            return;
        end
        m_start = 1'b0;
        m_to    = 1'b0;
        if (m_owner < 0) begin
            if (rq != 4'd0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && rq[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                end
                m_sel   = m_owner;
                m_age   = 0;
                m_start = 1'b1;
                $display("[TB] t=%0t grant to requester %0d", $time, m_owner);
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (md) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_age == MAX_WAIT) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    task automatic compare_all();
        check("grant",   32'(grant),   (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("sel",     32'(sel),     32'(m_sel));
        check("start",   32'(start),   32'(m_start));
        check("busy",    32'(busy),    32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    // One clock: drive on the falling edge, step the model at the rising edge,
    // compare 1 time unit later.
    task automatic step(input logic [3:0] rq, input logic md, input logic rs);
        @(negedge clk);
        req = rq; mem_done = md; reset = rs;
        @(posedge clk);
        model_edge(rq, md, rs);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(4'd0, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b1);
    endtask

    logic [3:0] exp_seq [5];
    int         seen;

    initial begin
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

        // ---- Scenario 1: reset state, single request, completion ----
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sel",   32'(sel),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        step(4'b0001, 1'b0, 1'b0);
        check("s1_grant", 32'(grant), 32'b0001);
        check("s1_sel",   32'(sel),   32'd0);
        check("s1_busy",  32'(busy),  32'd1);
        check("s1_start", 32'(start), 32'd1);
        step(4'b0000, 1'b0, 1'b0);
        check("s1_start_low", 32'(start), 32'd0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("s1_rel_grant", 32'(grant), 32'd0);
        check("s1_rel_busy",  32'(busy),  32'd0);
        check("s1_sel_hold",  32'(sel),   32'd0);

        // ---- Scenario 2: all requesting, round robin ----
        do_reset();
        for (int g = 0; g < 5; g++) begin
            step(4'b1111, 1'b0, 1'b0);          // grant edge
            check("s2_grant", 32'(grant), 32'(exp_seq[g]));
            check("s2_sel",   32'(sel),   32'((g % 4)));
            step(4'b1111, 1'b0, 1'b0);          // into WAIT
            step(4'b1111, 1'b0, 1'b0);
            step(4'b1111, 1'b1, 1'b0);          // done, release
            check("s2_idle", 32'(busy), 32'd0);
        end

        // ---- Scenario 3: ptr moves past requester 1 ----
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        check("s3_grant_a", 32'(grant), 32'b0100);
        check("s3_sel_a",   32'(sel),   32'd2);
        step(4'b0101, 1'b0, 1'b0);
        step(4'b0101, 1'b1, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        check("s3_grant_b", 32'(grant), 32'b0001);
        check("s3_sel_b",   32'(sel),   32'd0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // ---- Scenario 4: timeout, ptr becomes 2 ----
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        seen = 0;
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            step(4'b0000, 1'b0, 1'b0);
            if (timeout === 1'b1) seen = c;
        end
        check("s4_to_cycle", 32'(seen), 32'd16);
        check("s4_grant",    32'(grant), 32'd0);
        step(4'b0000, 1'b0, 1'b0);
        check("s4_to_pulse", 32'(timeout), 32'd0);
        step(4'b1111, 1'b0, 1'b0);
        check("s4_ptr2", 32'(grant), 32'b0100);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // ---- Scenario 5: done on the last WAIT cycle wins ----
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        for (int c = 0; c < 15; c++) step(4'b0000, 1'b0, 1'b0);
        check("s5_still_busy", 32'(busy), 32'd1);
        step(4'b0000, 1'b1, 1'b0);
        check("s5_timeout", 32'(timeout), 32'd0);
        check("s5_grant",   32'(grant),   32'd0);

        // ---- Scenario 6: reset during WAIT with sel=3 ----
        do_reset();
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("s6_sel3", 32'(sel), 32'd3);
        step(4'b0000, 1'b0, 1'b1);
        check("s6_outs", 32'({grant, sel, start, busy, timeout}), 32'd0);
        step(4'b1001, 1'b0, 1'b0);
        check("s6_grant", 32'(grant), 32'b0001);

        // ---- Randomized run against the model ----
        for (int c = 0; c < 600; c++) begin
            logic [3:0] rq;
            logic       md, rs;
            rq = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            md = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 60) == 0);
            step(rq, md, rs);
            check("onehot", 32'($countones(grant) <= 1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_port_arbiter.md
MUX_PORT_ARBITER -- requirements
Module: mux_port_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 15, the maximum number of WAIT-state cycles before a grant is forcibly released; legal range 1..15.
REQ-002 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset.
REQ-004 Port: req, input, 4, level request per requester; bit i is requester i.
REQ-005 Port: mem_done, input, 1, completion pulse from the shared resource.
REQ-006 Port: grant, output, 4, one-hot grant; all zero when no grant is held.
REQ-007 Port: sel, output, 2, select for the shared 4:1 datapath mux; equals the index of the granted requester.
REQ-008 Port: start, output, 1, one-cycle pulse telling the resource to begin.
REQ-009 Port: busy, output, 1, high while a grant is held (START or WAIT).
REQ-010 Port: timeout, output, 1, one-cycle pulse on forced release.
REQ-011 The design has one clock; reset is synchronous and active-high.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, START, WAIT.
REQ-013 In IDLE with req != 0, the block SHALL pick the first set bit searching from ptr upward (mod 4) and SHALL register grant and sel to that index.
- It SHALL then go to START.
REQ-014 Latency: if req is sampled at edge t, grant/sel/busy SHALL be valid after edge t, and start SHALL be high only in the cycle following edge t.
REQ-015 START SHALL last exactly one cycle and SHALL then go to WAIT with wait_cnt = 0.
REQ-016 In WAIT, wait_cnt (4-bit) SHALL increment by 1 each cycle in which mem_done = 0.
REQ-017 On WAIT with mem_done = 1, the block SHALL release.
- At the next edge: grant = 0, busy = 0, ptr = (sel+1) mod 4, state = IDLE.
REQ-018 On WAIT with mem_done = 0 and wait_cnt == MAX_WAIT-1, the block SHALL force release as in REQ-017 and SHALL pulse timeout for one cycle.
REQ-019 If mem_done and the timeout condition coincide, mem_done SHALL win and timeout SHALL stay low.
REQ-020 mem_done SHALL be ignored in IDLE and START.
REQ-021 Deassertion of req during START/WAIT SHALL NOT abort the grant.
- The grant is held until mem_done or timeout.
REQ-022 At least one IDLE cycle SHALL separate consecutive grants.
- The maximum grant rate is one per 3 cycles.
REQ-023 sel SHALL hold its last granted value while IDLE, so the mux output is stable and glitch-free.
REQ-024 grant SHALL never have more than one bit set.
REQ-025 Changes to req in IDLE SHALL affect only the arbitration decision at the next edge.
- No combinational path from req to any output.
REQ-026 Fairness: with all four requesters continuously asserting, each SHALL be granted once in every four grants.

Reset
REQ-027 While reset = 1 at an edge, the block SHALL set state = IDLE, grant = 0, sel = 0, start = 0, busy = 0, timeout = 0, ptr = 0, wait_cnt = 0.
REQ-028 Reset asserted mid-START or mid-WAIT SHALL abort the grant at that edge with no timeout pulse.
- The first post-reset arbitration SHALL search from requester 0.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Reset, then req=0001 -> next cycle grant=0001, sel=0, busy=1, start=1 for one cycle; mem_done 3 cycles later -> grant=0000, busy=0 after that edge.
- req=1111 held, mem_done 2 cycles into each WAIT -> grant sequence 0001, 0010, 0100, 1000, 0001, with sel 0,1,2,3,0.
- Grant to requester 1 completes, then req=0101 -> grant=0100 (sel=2), then after done grant=0001 (sel=0).
- req=0010, mem_done never asserted, MAX_WAIT=15 -> timeout pulse in the cycle after the 15th WAIT cycle, grant released, ptr=2.
- mem_done on the final WAIT cycle (wait_cnt=14) -> normal release, timeout stays 0.
- Reset asserted in WAIT with sel=3 -> all outputs 0 next cycle; then req=1001 -> grant=0001.
